// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data-port interconnect: FSM state encoding,
// default widths, strobe width and the standard memory map (4 KiB windows).
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    localparam int BUS_ADDR_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_STRB_WIDTH = BUS_DATA_WIDTH / 8;
    localparam int BUS_NUM_SLAVES = 4;

    // Width of the optional ready-wait counter.
    localparam int BUS_TO_CNT_W = 16;

    // Standard map: RAM @0x0000, timer @0x1000, UART @0x2000, spare @0x3000.
    localparam logic [BUS_NUM_SLAVES*BUS_ADDR_WIDTH-1:0] BUS_DEFAULT_BASE =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [BUS_NUM_SLAVES*BUS_ADDR_WIDTH-1:0] BUS_DEFAULT_MASK =
        {4{32'hFFFF_F000}};

    // Number of byte lanes for a given data width.
    function automatic int bus_strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: slave i hits when (addr & mask_i) == base_i.
// Overlapping windows resolve to the lowest index; miss_o flags an unmapped
// address. Also usable for read-data muxing at the top level.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int NUM_SLAVES = BUS_NUM_SLAVES,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = BUS_DEFAULT_BASE,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = BUS_DEFAULT_MASK
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic                  miss_o
);

    logic [NUM_SLAVES-1:0] raw_hit_s;

    // Compare the address against every window.
    always_comb begin
        raw_hit_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            raw_hit_s[i] = ((addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                            == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Keep only the lowest set bit (x & -x) so the result is one-hot.
    assign hit_o  = raw_hit_s & (~raw_hit_s + NUM_SLAVES'(1));
    assign miss_o = ~(|raw_hit_s);

endmodule

// File: rtl/data_bus_interconnect.sv
// CPU data port to NUM_SLAVES address-decoded targets over a req/ready
// handshake. Supports wait states, byte strobes and an unmapped-address error.
// A simultaneous read and write is split into a write followed by a read.
// Optional macro BUS_TIMEOUT_EN: abort an access that sees no ready within
// TIMEOUT_CYCLES and complete it as an error.
module data_bus_interconnect
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
    parameter int NUM_SLAVES     = BUS_NUM_SLAVES,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = BUS_DEFAULT_BASE,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = BUS_DEFAULT_MASK,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cpu_rd_en,
    input  logic                             cpu_wr_en,
    input  logic [ADDR_WIDTH-1:0]            cpu_rd_addr,
    input  logic [ADDR_WIDTH-1:0]            cpu_wr_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_wr_data,
    input  logic [DATA_WIDTH/8-1:0]          cpu_wr_strb,
    output logic [DATA_WIDTH-1:0]            cpu_rd_data,
    output logic                             cpu_stall,
    output logic                             cpu_err,
    output logic [NUM_SLAVES-1:0]            s_req,
    output logic                             s_we,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_strb,
    input  logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    bus_state_e              state_q;
    logic [NUM_SLAVES-1:0]   s_req_q;
    logic                    s_we_q;
    logic [ADDR_WIDTH-1:0]   s_addr_q;
    logic [DATA_WIDTH-1:0]   s_wdata_q;
    logic [STRB_W-1:0]       s_strb_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    err_q;
    logic                    pend_rd_q;

    logic                    launch_s;
    logic                    launch_we_s;
    logic [ADDR_WIDTH-1:0]   dec_addr_s;
    logic [NUM_SLAVES-1:0]   dec_hit_s;
    logic                    dec_miss_s;
    logic                    ready_hit_s;
    logic                    timeout_s;
    logic [DATA_WIDTH-1:0]   rdata_sel_s;
    logic                    stall_s;

    // A new transaction starts from IDLE on any request, or from RESP when a
    // read is still queued behind a write.
    always_comb begin
        launch_s    = 1'b0;
        launch_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                launch_s    = cpu_rd_en | cpu_wr_en;
                launch_we_s = cpu_wr_en;
            end
            ST_RESP: begin
                launch_s    = pend_rd_q;
                launch_we_s = 1'b0;
            end
            default: begin
                launch_s    = 1'b0;
                launch_we_s = 1'b0;
            end
        endcase
    end

    // Writes take priority, so decode the write address whenever one launches.
    always_comb begin
        dec_addr_s = cpu_rd_addr;
        if (launch_we_s) begin
            dec_addr_s = cpu_wr_addr;
        end else begin
            dec_addr_s = cpu_rd_addr;
        end
    end

    bus_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .addr_i (dec_addr_s),
        .hit_o  (dec_hit_s),
        .miss_o (dec_miss_s)
    );

    // Only the ready of the currently requested slave completes an access.
    assign ready_hit_s = |(s_ready & s_req_q);

    // AND-OR mux of the selected slave's read data (s_req_q is one-hot).
    always_comb begin
        rdata_sel_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rdata_sel_s = rdata_sel_s
                        | (s_rdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{s_req_q[i]}});
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [BUS_TO_CNT_W-1:0] to_cnt_q;

    // Count ACCESS cycles; the counter rests at zero outside ACCESS so it is
    // clear on every ACCESS entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            to_cnt_q <= to_cnt_q + BUS_TO_CNT_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign timeout_s = (state_q == ST_ACCESS)
                     && (to_cnt_q == BUS_TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Main transaction FSM with all bus-side and CPU-side outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            s_req_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_strb_q  <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            pend_rd_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (launch_s) begin
                        s_we_q    <= launch_we_s;
                        s_addr_q  <= dec_addr_s;
                        pend_rd_q <= launch_we_s & cpu_rd_en;
                        if (launch_we_s) begin
                            s_wdata_q <= cpu_wr_data;
                            s_strb_q  <= cpu_wr_strb;
                        end else begin
                            s_wdata_q <= s_wdata_q;
                            s_strb_q  <= '0;
                        end
                        if (dec_miss_s) begin
                            // Unmapped: no slave request, error completion.
                            state_q <= ST_RESP;
                            s_req_q <= '0;
                            err_q   <= 1'b1;
                            if (!launch_we_s) begin
                                rd_data_q <= '0;
                            end else begin
                                rd_data_q <= rd_data_q;
                            end
                        end else begin
                            state_q <= ST_ACCESS;
                            s_req_q <= dec_hit_s;
                        end
                    end else begin
                        state_q   <= ST_IDLE;
                        pend_rd_q <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (ready_hit_s) begin
                        state_q <= ST_RESP;
                        s_req_q <= '0;
                        if (!s_we_q) begin
                            rd_data_q <= rdata_sel_s;
                        end else begin
                            rd_data_q <= rd_data_q;
                        end
                    end else if (timeout_s) begin
                        state_q <= ST_RESP;
                        s_req_q <= '0;
                        err_q   <= 1'b1;
                        if (!s_we_q) begin
                            rd_data_q <= '0;
                        end else begin
                            rd_data_q <= rd_data_q;
                        end
                    end else begin
                        state_q <= ST_ACCESS;
                        s_req_q <= s_req_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_req_q   <= '0;
                    pend_rd_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall rises in the request cycle itself, stays up while the bus is busy
    // and drops in the final RESP cycle so the CPU advances on that edge.
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            ST_IDLE:   stall_s = cpu_rd_en | cpu_wr_en;
            ST_ACCESS: stall_s = 1'b1;
            ST_RESP:   stall_s = pend_rd_q;
            default:   stall_s = 1'b0;
        endcase
    end

    // Reset forces the stall low immediately, even with a request held.
    assign cpu_stall   = stall_s & rst;
    assign cpu_rd_data = rd_data_q;
    assign cpu_err     = err_q;
    assign s_req       = s_req_q;
    assign s_we        = s_we_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_strb      = s_strb_q;

endmodule

// File: tb/tb_data_bus_interconnect.sv
// Scoreboard bench for data_bus_interconnect: stimulus pushes expected slave
// handshakes and CPU completions into queues; monitors pop and compare.
module tb_data_bus_interconnect;

    logic         clk;
    logic         rst;
    logic         cpu_rd_en;
    logic         cpu_wr_en;
    logic [31:0]  cpu_rd_addr;
    logic [31:0]  cpu_wr_addr;
    logic [31:0]  cpu_wr_data;
    logic [3:0]   cpu_wr_strb;
    logic [31:0]  cpu_rd_data;
    logic         cpu_stall;
    logic         cpu_err;
    logic [3:0]   s_req;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_strb;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;

    logic [31:0]  slv_data [4];
    int           wait_states;
    bit           noise;
    bit           hold_ready;
    int           ws_cnt;
    int           req_cycles;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0]  req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          hold;
    } slv_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } cpu_exp_t;

    slv_exp_t slv_q[$];
    cpu_exp_t cpu_q[$];

    data_bus_interconnect #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rd_en   (cpu_rd_en),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_rd_addr (cpu_rd_addr),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_wr_strb (cpu_wr_strb),
        .cpu_rd_data (cpu_rd_data),
        .cpu_stall   (cpu_stall),
        .cpu_err     (cpu_err),
        .s_req       (s_req),
        .s_we        (s_we),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_strb      (s_strb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_rdata = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_slv(input logic [3:0] req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input int hold);
        slv_exp_t e;
        e.req = req; e.we = we; e.addr = addr; e.wdata = wdata; e.strb = strb; e.hold = hold;
        slv_q.push_back(e);
    endtask

    task automatic push_cpu(input logic [31:0] rdata, input logic err);
        cpu_exp_t e;
        e.rdata = rdata; e.err = err;
        cpu_q.push_back(e);
    endtask

    // Drive one CPU request, hold it while stalled, check the release latency.
    task automatic do_txn(input string name, input logic rd, input logic wr,
                          input logic [31:0] raddr, input logic [31:0] waddr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int exp_cycles);
        int  n;
        bit  done;
        @(posedge clk); #1;
        cpu_rd_en = rd; cpu_wr_en = wr;
        cpu_rd_addr = raddr; cpu_wr_addr = waddr;
        cpu_wr_data = wdata; cpu_wr_strb = strb;
        n = 0; done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (!cpu_stall) done = 1'b1;
        end
        chk({name, "_cycles"}, n, exp_cycles);
        @(posedge clk); #1;
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    endtask

    // Slave model: per-access wait states, optional stray ready on other slaves.
    initial begin
        s_ready = 4'b0000;
        ws_cnt  = 0;
        forever begin
            @(posedge clk); #1;
            if (s_req == 4'b0000) begin
                s_ready = 4'b0000;
                ws_cnt  = 0;
            end else if (!hold_ready && ws_cnt >= wait_states) begin
                s_ready = s_req;
            end else begin
                s_ready = noise ? ~s_req : 4'b0000;
                ws_cnt++;
            end
        end
    end

    // Monitor: slave handshakes and CPU completions against the queues.
    initial begin
        slv_exp_t se;
        cpu_exp_t ce;
        req_cycles = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (s_req != 4'b0000) req_cycles++;
                if (|(s_req & s_ready)) begin
                    if (slv_q.size() == 0) begin
                        chk("unexpected_slave_req", {28'd0, s_req}, 32'd0);
                    end else begin
                        se = slv_q.pop_front();
                        chk("s_req", {28'd0, s_req}, {28'd0, se.req});
                        chk("s_we", {31'd0, s_we}, {31'd0, se.we});
                        chk("s_addr", s_addr, se.addr);
                        if (se.we) begin
                            chk("s_wdata", s_wdata, se.wdata);
                            chk("s_strb", {28'd0, s_strb}, {28'd0, se.strb});
                        end
                        if (se.hold > 0) chk("req_hold_cycles", req_cycles, se.hold);
                    end
                end
                if (s_req == 4'b0000) req_cycles = 0;
                if ((cpu_rd_en || cpu_wr_en) && !cpu_stall) begin
                    if (cpu_q.size() == 0) begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        ce = cpu_q.pop_front();
                        chk("cpu_rd_data", cpu_rd_data, ce.rdata);
                        chk("cpu_err", {31'd0, cpu_err}, {31'd0, ce.err});
                    end
                end else begin
                    chk("cpu_err_outside_completion", {31'd0, cpu_err}, 32'd0);
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_errors = 0;
        slv_data[0] = 32'hDEAD_BEEF;
        slv_data[1] = 32'hCAFE_F00D;
        slv_data[2] = 32'h5A5A_1234;
        slv_data[3] = 32'h0BAD_C0DE;
        wait_states = 0; noise = 1'b0; hold_ready = 1'b0;
        rst = 1'b0;
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
        cpu_rd_addr = 32'd0; cpu_wr_addr = 32'd0;
        cpu_wr_data = 32'd0; cpu_wr_strb = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_s_req", {28'd0, s_req}, 32'd0);
        chk("rst_s_we", {31'd0, s_we}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_s_strb", {28'd0, s_strb}, 32'd0);
        chk("rst_rd_data", cpu_rd_data, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_err", {31'd0, cpu_err}, 32'd0);
        rst = 1'b1;

        // Read slave 0, ready tied high: 3-cycle release
        push_slv(4'b0001, 1'b0, 32'h0000_0010, 32'd0, 4'd0, 1);
        push_cpu(32'hDEAD_BEEF, 1'b0);
        do_txn("rd_s0", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'd0, 4'd0, 3);

        // Write slave 2 with 4 wait states and stray ready on other slaves
        wait_states = 4; noise = 1'b1;
        push_slv(4'b0100, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 5);
        push_cpu(32'hDEAD_BEEF, 1'b0);
        do_txn("wr_s2", 1'b0, 1'b1, 32'd0, 32'h0000_2004, 32'h1234_5678, 4'b0011, 7);
        wait_states = 0; noise = 1'b0;

        // Simultaneous read and write: write to slave 0 first, then read slave 1
        push_slv(4'b0001, 1'b1, 32'h0000_0008, 32'hA5A5_0F0F, 4'b1111, 1);
        push_slv(4'b0010, 1'b0, 32'h0000_1000, 32'd0, 4'd0, 1);
        push_cpu(32'hCAFE_F00D, 1'b0);
        do_txn("rdwr", 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0008, 32'hA5A5_0F0F, 4'b1111, 5);

        // Unmapped read: error pulse, read data cleared, no slave request
        push_cpu(32'd0, 1'b1);
        do_txn("rd_miss", 1'b1, 1'b0, 32'h0000_8000, 32'd0, 32'd0, 4'd0, 2);

        // Read slave 3 at the top of its window with 2 wait states
        wait_states = 2;
        push_slv(4'b1000, 1'b0, 32'h0000_3FFC, 32'd0, 4'd0, 3);
        push_cpu(32'h0BAD_C0DE, 1'b0);
        do_txn("rd_s3", 1'b1, 1'b0, 32'h0000_3FFC, 32'd0, 32'd0, 4'd0, 5);
        wait_states = 0;

        // Async reset during ACCESS
        hold_ready = 1'b1;
        @(posedge clk); #1;
        cpu_rd_en = 1'b1; cpu_rd_addr = 32'h0000_3000;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_s_req", {28'd0, s_req}, 32'h8);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_s_req", {28'd0, s_req}, 32'd0);
        chk("async_rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("async_rst_rd_data", cpu_rd_data, 32'd0);
        cpu_rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hold_ready = 1'b0;
        push_slv(4'b0010, 1'b0, 32'h0000_1234, 32'd0, 4'd0, 1);
        push_cpu(32'hCAFE_F00D, 1'b0);
        do_txn("rd_after_rst", 1'b1, 1'b0, 32'h0000_1234, 32'd0, 32'd0, 4'd0, 3);

        // Ready never arrives
        hold_ready = 1'b1;
`ifdef BUS_TIMEOUT_EN
        push_cpu(32'd0, 1'b1);
        do_txn("timeout", 1'b1, 1'b0, 32'h0000_2010, 32'd0, 32'd0, 4'd0, 10);
        hold_ready = 1'b0;
`else
        begin
            int  n;
            bit  done;
            push_slv(4'b0100, 1'b0, 32'h0000_2010, 32'd0, 4'd0, -1);
            push_cpu(32'h5A5A_1234, 1'b0);
            @(posedge clk); #1;
            cpu_rd_en = 1'b1; cpu_rd_addr = 32'h0000_2010;
            repeat (100) @(negedge clk);
            chk("hang_s_req", {28'd0, s_req}, 32'h4);
            chk("hang_stall", {31'd0, cpu_stall}, 32'd1);
            hold_ready = 1'b0;
            n = 0; done = 1'b0;
            while (!done && n < 20) begin
                @(negedge clk);
                n++;
                if (!cpu_stall) done = 1'b1;
            end
            chk("hang_release", {31'd0, done}, 32'd1);
            @(posedge clk); #1;
            cpu_rd_en = 1'b0;
        end
`endif

        repeat (3) @(negedge clk);
        chk("slv_q_left", slv_q.size(), 32'd0);
        chk("cpu_q_left", cpu_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_bus_interconnect.md
Name: data_bus_interconnect

Overview:
- Parametrised successor to the single-data-memory hookup: routes the CPU data port to NUM_SLAVES address-decoded targets (data RAM, timer, UART, ...) through a req/ready handshake.
- Adds wait states, write byte strobes and an unmapped-address error.
- Serialises a simultaneous read and write, write first.
- Sits between riscv_cpu data-port signals and the memory/peripheral blocks in the top level.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- NUM_SLAVES, 4, number of targets, 1..8.
- SLAVE_BASE, {32'h0000_3000,32'h0000_2000,32'h0000_1000,32'h0000_0000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slave i occupies slice i.
- SLAVE_MASK, {4{32'hFFFF_F000}}, packed decode masks; slave i hits when (addr & mask_i) == base_i.
- TIMEOUT_CYCLES, 255, ready-wait limit; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_rd_en  in  1  read request.
- cpu_wr_en  in  1  write request.
- cpu_rd_addr  in  ADDR_WIDTH  read address.
- cpu_wr_addr  in  ADDR_WIDTH  write address.
- cpu_wr_data  in  DATA_WIDTH  write data.
- cpu_wr_strb  in  DATA_WIDTH/8  byte enables for writes.
- cpu_rd_data  out  DATA_WIDTH  registered read data.
- cpu_stall  out  1  CPU must hold its request inputs stable while high.
- cpu_err  out  1  one-cycle pulse on error completion.
- s_req  out  NUM_SLAVES  one-hot request, held until ready.
- s_we  out  1  write qualifier.
- s_addr  out  ADDR_WIDTH  address, offset-free, passed through.
- s_wdata  out  DATA_WIDTH  write data.
- s_strb  out  DATA_WIDTH/8  byte enables.
- s_ready  in  NUM_SLAVES  per-slave completion.
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, valid with ready.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; s_req=0, s_we=0, s_addr/s_wdata/s_strb=0; cpu_rd_data=0, cpu_stall=0, cpu_err=0; pending-read flag cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If wr_en: decode cpu_wr_addr; latch addr/data/strb; s_we=1.
  - Else if rd_en: decode cpu_rd_addr; s_we=0.
  - If both rd_en and wr_en: write first; set pending_rd.
  - Hit: assert the one-hot s_req next cycle; enter ACCESS.
  - Miss: go to RESP with err set and no s_req.
  - Multiple hits: lowest index wins.
  - cpu_stall rises combinationally in the request cycle whenever rd_en or wr_en is high in IDLE.
- ACCESS: hold s_req and payload stable until s_ready[sel]. Ready on a non-selected slave is ignored. On ready: capture s_rdata[sel] for reads (writes leave cpu_rd_data unchanged); drop s_req the same edge; enter RESP.
- RESP: one cycle. cpu_err pulses if error. If pending_rd: clear it, decode cpu_rd_addr, re-enter ACCESS (or error RESP); cpu_stall stays high. Otherwise cpu_stall=0 and return to IDLE.
- Minimum latency: 3 cycles request-to-release with ready tied high; 5 cycles for a combined read+write.
- Read on miss: cpu_rd_data = 0. Write on miss: discarded.
- Reset mid-transaction: s_req drops immediately; no completion; pending_rd lost.
- Request inputs sampled only in IDLE and at pending-read launch; changes in other states are ignored.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on ACCESS entry and increments each ACCESS cycle. At TIMEOUT_CYCLES without ready: drop s_req, complete as error (read data 0), go to RESP.
- Undefined: ACCESS waits indefinitely; counter absent.

Decomposition:
- Shared package bus_pkg: state encoding (IDLE/ACCESS/RESP), DATA_WIDTH/8 strobe-width constant, default base/mask constants for the standard memory map.
- One sub-module: bus_addr_decoder. Combinational, parametrised by NUM_SLAVES/SLAVE_BASE/SLAVE_MASK; outputs one-hot hit vector plus miss flag with lowest-index priority; reused by top-level peripheral muxing.

Test Plan:
- Read slave 0 with ready tied high: rd_addr=0x0000_0010, s_rdata[0]=0xDEAD_BEEF -> s_req=4'b0001 for 1 cycle, s_we=0; cpu_rd_data=0xDEAD_BEEF; stall released after 3 cycles; cpu_err=0.
- Write slave 2 with 4 wait states: wr_addr=0x0000_2004, data=0x1234_5678, strb=4'b0011 -> s_req=4'b0100 held 5 cycles; s_we=1, s_strb=0011; stall held throughout; no error.
- Simultaneous rd (0x1000) and wr (0x0008) -> write transaction to slave 0 completes first, then read to slave 1; stall continuous; total 5 cycles.
- Unmapped read 0x0000_8000 -> no s_req; cpu_err pulses one cycle; cpu_rd_data=0.
- Async reset asserted during ACCESS -> s_req=0 and stall=0 immediately, before the next clk edge; next request after reset completes normally.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8 and ready held low -> s_req drops after 8 ACCESS cycles; cpu_err pulses; IDLE follows. Without the macro, the bus still waits at cycle 100.
